// File: rtl/i3c_timec_sequencer.sv
// -----------------------------------------------------------------------------
// i3c_timec_sequencer
//
// Controls the timing-control capture block. On a request it strobes
// event_start, waits for the capture to finish, lets the TC registers settle,
// and then streams the captured TC bytes to the IBI engine over a valid/ready
// handshake. It selects each byte through time_info_sel.
//
// Optional feature macro: I3C_TIMEC_HDR_EN
//   defined   : a header byte {ovf_flag, 4'b0, mode} (time_info_sel=4) is
//               sent before the TC bytes.
//   undefined : only TC bytes are sent; byte_data always comes from
//               time_info_byte.
//
// Ports
//   RSTn           async active-low reset
//   CLK_SLOW       block clock
//   timec_ena      mode: 0 off, [1] -> 3 TC bytes, otherwise 2 TC bytes
//   ev_req         single-cycle request to start a timed event
//   cap_done       capture complete pulse
//   abort          synchronous cancel, highest priority
//   time_overflow  overflow pulse from the time control block
//   time_info_byte byte selected by time_info_sel
//   event_start    start strobe to the time control block
//   time_info_sel  byte select to the time control block
//   byte_valid     byte_data valid
//   byte_ready     IBI engine accepts byte_data
//   byte_data      outgoing byte (0 while byte_valid is low)
//   busy           high in every state except IDLE
//   done / err     end-of-sequence pulse, err marks a capture timeout
//   ovf_flag       sticky overflow seen during the current/last sequence
//   ev_drop        pulse: ev_req ignored because the sequencer was busy
// -----------------------------------------------------------------------------
module i3c_timec_sequencer #(
  parameter int START_CYC  = 4,
  parameter int SETTLE_CYC = 4,
  parameter int TMO_W      = 12
) (
  input  logic       RSTn,
  input  logic       CLK_SLOW,
  input  logic [2:0] timec_ena,
  input  logic       ev_req,
  input  logic       cap_done,
  input  logic       abort,
  input  logic       time_overflow,
  input  logic [7:0] time_info_byte,
  output logic       event_start,
  output logic [2:0] time_info_sel,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ovf_flag,
  output logic       ev_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_CAP,
    S_SETTLE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [3:0] START_LD  = 4'(START_CYC - 1);
  localparam logic [3:0] SETTLE_LD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

`ifdef I3C_TIMEC_HDR_EN
  localparam logic [2:0] FIRST_SEL = 3'd4;
  localparam logic [1:0] HDR_BYTES = 2'd1;
`else
  localparam logic [2:0] FIRST_SEL = 3'd5;
  localparam logic [1:0] HDR_BYTES = 2'd0;
`endif

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       idx_q;
  logic             three_q;
  logic             pend_q;
  logic             es_q;
  logic [2:0]       sel_q;
  logic             valid_q;
  logic             done_q;
  logic             err_q;
  logic             ovf_q;
  logic             drop_q;
`ifdef I3C_TIMEC_HDR_EN
  logic [2:0]       mode_q;
`endif

  // Index of the final byte of a sequence, header included when present.
  function automatic logic [1:0] last_index(input logic three_byte);
    last_index = (three_byte ? 2'd2 : 2'd1) + HDR_BYTES;
  endfunction

  always_ff @(posedge CLK_SLOW or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      three_q <= 1'b0;
      pend_q  <= 1'b0;
      es_q    <= 1'b0;
      sel_q   <= 3'h0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
`ifdef I3C_TIMEC_HDR_EN
      mode_q  <= 3'h0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;

      // Overflow is recorded in any active state, including the cycle abort
      // arrives; an abort keeps the flag.
      if (time_overflow && (state_q != S_IDLE)) ovf_q <= 1'b1;

      if (abort) begin
        state_q <= S_IDLE;
        es_q    <= 1'b0;
        valid_q <= 1'b0;
        sel_q   <= 3'h0;
        pend_q  <= 1'b0;
      end else begin
        if (ev_req && (state_q != S_IDLE)) drop_q <= 1'b1;

        case (state_q)
          S_IDLE: begin
            if (ev_req) begin
              three_q <= timec_ena[1];
`ifdef I3C_TIMEC_HDR_EN
              mode_q  <= timec_ena;
`endif
              ovf_q   <= 1'b0;
              pend_q  <= 1'b0;
              if (timec_ena == 3'h0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_START;
                es_q    <= 1'b1;
                cnt_q   <= START_LD;
              end
            end
          end

          S_START: begin
            // A capture that completes while the start strobe is still being
            // held is kept and honoured once WAIT_CAP is reached.
            if (cap_done) pend_q <= 1'b1;
            if (cnt_q == 4'd0) begin
              es_q    <= 1'b0;
              tmo_q   <= '0;
              state_q <= S_WAIT_CAP;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end

          S_WAIT_CAP: begin
            // cap_done is tested before the timeout so a simultaneous capture
            // still counts as success.
            if (cap_done || pend_q) begin
              pend_q <= 1'b0;
              if (SETTLE_CYC == 0) begin
                state_q <= S_SEND;
                valid_q <= 1'b1;
                sel_q   <= FIRST_SEL;
                idx_q   <= 2'd0;
              end else begin
                state_q <= S_SETTLE;
                cnt_q   <= SETTLE_LD;
              end
            end else if (&tmo_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end

          S_SETTLE: begin
            if (cnt_q == 4'd0) begin
              state_q <= S_SEND;
              valid_q <= 1'b1;
              sel_q   <= FIRST_SEL;
              idx_q   <= 2'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end

          S_SEND: begin
            // valid_q is always set here, so ready alone marks a transfer.
            if (byte_ready) begin
              if (idx_q == last_index(three_q)) begin
                valid_q <= 1'b0;
                sel_q   <= 3'h0;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 2'd1;
                sel_q <= sel_q + 3'd1;
              end
            end
          end

          S_DONE: begin
            state_q <= S_IDLE;
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign event_start   = es_q;
  assign time_info_sel = sel_q;
  assign byte_valid    = valid_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign ovf_flag      = ovf_q;
  assign ev_drop       = drop_q;

`ifdef I3C_TIMEC_HDR_EN
  assign byte_data = !valid_q ? 8'h00 :
                     (idx_q == 2'd0) ? {ovf_q, 4'b0000, mode_q} : time_info_byte;
`else
  assign byte_data = valid_q ? time_info_byte : 8'h00;
`endif

endmodule

// File: tb/tb_i3c_timec_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for i3c_timec_sequencer. Each sequence is described by a few event
// times (request, capture, overflow, extra request, abort); a timeline model
// derives the expected cycle of every strobe, byte and pulse from those times
// and the block's documented latencies, and every output is compared each
// cycle. Honours I3C_TIMEC_HDR_EN when defined.
// -----------------------------------------------------------------------------
module tb_i3c_timec_sequencer;

  localparam int START_CYC  = 4;
  localparam int SETTLE_CYC = 4;
  localparam int TMO_W      = 4;
  localparam int TMO_CYC    = 1 << TMO_W;
`ifdef I3C_TIMEC_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FIRST_SEL = 5 - HDR;

  logic       RSTn;
  logic       CLK_SLOW;
  logic [2:0] timec_ena;
  logic       ev_req;
  logic       cap_done;
  logic       abort;
  logic       time_overflow;
  logic [7:0] time_info_byte;
  logic       event_start;
  logic [2:0] time_info_sel;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       ovf_flag;
  logic       ev_drop;

  logic [7:0] tc_mem [0:7];
  assign time_info_byte = tc_mem[time_info_sel];

  i3c_timec_sequencer #(
    .START_CYC (START_CYC),
    .SETTLE_CYC(SETTLE_CYC),
    .TMO_W     (TMO_W)
  ) dut (
    .RSTn          (RSTn),
    .CLK_SLOW      (CLK_SLOW),
    .timec_ena     (timec_ena),
    .ev_req        (ev_req),
    .cap_done      (cap_done),
    .abort         (abort),
    .time_overflow (time_overflow),
    .time_info_byte(time_info_byte),
    .event_start   (event_start),
    .time_info_sel (time_info_sel),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_data     (byte_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .ovf_flag      (ovf_flag),
    .ev_drop       (ev_drop)
  );

  initial CLK_SLOW = 1'b0;
  always #5 CLK_SLOW = ~CLK_SLOW;

  int n_chk = 0;
  int n_err = 0;
  int seq_no = 0;
  int cur_t = 0;
  bit ovf_model = 1'b0;
  logic [2:0] mode_tab [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s seq=%0d t=%0d: got %0h expected %0h", tag, seq_no, cur_t, act, exp);
    end
  endtask

  // One sequence: request at t=0, optional capture/overflow/extra request/
  // abort at given relative cycles (-1 = none).
  task automatic run_seq(input logic [2:0] mode, input int cap_c, input int rdy_mode,
                         input int ovf_c, input int drop_in, input int abort_in,
                         input bit tc_rand);
    bit vm [0:255];
    int sm [0:255];
    bit rd [0:255];
    int W, C, S, D, L, k, t, hold, nb, drop_c, abort_c;
    bit to_err, accepted, ovf_hit, ovf_prev, live, ovf_t, valid_e, drop_e, done_e;
    logic [7:0] data_e;
    logic [2:0] sel_e;

    seq_no++;
    for (int i = 0; i < 256; i++) begin
      vm[i] = 1'b0;
      sm[i] = 0;
      rd[i] = ($urandom_range(3) != 0);
    end
    for (int i = 0; i < 8; i++) tc_mem[i] = 8'($urandom);
    if (!tc_rand) begin
      tc_mem[5] = 8'hA5;
      tc_mem[6] = 8'h3C;
      tc_mem[7] = 8'h5A;
    end

    // Timeline model.
    W = START_CYC + 1;
    to_err = 1'b0;
    if (mode == 3'd0) begin
      D = 1;
    end else begin
      if (cap_c >= 1 && cap_c <= START_CYC)          C = W;
      else if (cap_c >= W && cap_c <= W + TMO_CYC - 1) C = cap_c;
      else                                            C = -1;
      if (C < 0) begin
        D = W + TMO_CYC;
        to_err = 1'b1;
      end else begin
        S = C + SETTLE_CYC + 1;
        nb = (mode[1] ? 3 : 2) + HDR;
        k = 0;
        t = S;
        hold = 0;
        while (k < nb) begin
          vm[t] = 1'b1;
          sm[t] = FIRST_SEL + k;
          if (rdy_mode == 0) rd[t] = 1'b1;
          else if (rdy_mode == 2) begin
            if (k == 1 && hold < 3) begin
              rd[t] = 1'b0;
              hold++;
            end else rd[t] = 1'b1;
          end else if (t > 150) rd[t] = 1'b1;
          if (rd[t]) k++;
          t++;
        end
        D = t;
      end
    end

    abort_c = abort_in;
    if (abort_c > D) abort_c = -1;
    drop_c = drop_in;
    if (drop_c < 1 || drop_c > D || (abort_c >= 0 && drop_c > abort_c)) drop_c = -1;
    accepted = (abort_c != 0);
    ovf_hit = accepted && ovf_c >= 1 && ovf_c <= D && (abort_c < 0 || ovf_c <= abort_c);
    L = (abort_c >= 0 && abort_c < D) ? abort_c + 1 : D + 1;
    ovf_prev = ovf_model;

    for (t = 0; t <= L; t++) begin
      cur_t = t;
      ev_req        = (t == 0) || (t == drop_c);
      timec_ena     = (t == 0) ? mode : 3'($urandom);
      cap_done      = (t == cap_c) || (t == L && $urandom_range(1) == 1);
      abort         = (t == abort_c);
      time_overflow = (t == ovf_c) || (t == L && $urandom_range(1) == 1);
      byte_ready    = rd[t];
      @(negedge CLK_SLOW);

      live    = accepted && t >= 1 && t <= D && (abort_c < 0 || t <= abort_c);
      ovf_t   = (t == 0 || !accepted) ? ovf_prev : (ovf_hit && t >= ovf_c + 1);
      valid_e = live && vm[t];
      sel_e   = valid_e ? 3'(sm[t]) : 3'h0;
      if (!valid_e)                 data_e = 8'h00;
      else if (HDR == 1 && sm[t] == 4) data_e = {ovf_t, 4'b0000, mode};
      else                          data_e = tc_mem[sm[t]];
      done_e  = live && t == D;
      drop_e  = (drop_c >= 1) && (t == drop_c + 1) && (drop_c != abort_c);

      check_eq("busy",        32'(busy),        32'(live));
      check_eq("event_start", 32'(event_start), 32'(live && mode != 3'd0 && t <= START_CYC));
      check_eq("byte_valid",  32'(byte_valid),  32'(valid_e));
      check_eq("sel",         32'(time_info_sel), 32'(sel_e));
      check_eq("byte_data",   32'(byte_data),   32'(data_e));
      check_eq("done",        32'(done),        32'(done_e));
      check_eq("err",         32'(err),         32'(done_e && to_err));
      check_eq("ev_drop",     32'(ev_drop),     32'(drop_e));
      check_eq("ovf_flag",    32'(ovf_flag),    32'(ovf_t));

      @(posedge CLK_SLOW);
      #1;
    end
    ev_req = 1'b0;
    cap_done = 1'b0;
    abort = 1'b0;
    time_overflow = 1'b0;
    ovf_model = accepted ? ovf_hit : ovf_prev;
  endtask

  initial begin
    int m_i, r, cap, ovf, drp, abt;
    RSTn = 1'b0;
    timec_ena = 3'h0;
    ev_req = 1'b0;
    cap_done = 1'b0;
    abort = 1'b0;
    time_overflow = 1'b0;
    byte_ready = 1'b0;
    for (int i = 0; i < 8; i++) tc_mem[i] = 8'h00;

    repeat (3) @(negedge CLK_SLOW);
    check_eq("rst_event_start", 32'(event_start),   32'h0);
    check_eq("rst_sel",         32'(time_info_sel), 32'h0);
    check_eq("rst_valid",       32'(byte_valid),    32'h0);
    check_eq("rst_data",        32'(byte_data),     32'h0);
    check_eq("rst_busy",        32'(busy),          32'h0);
    check_eq("rst_done",        32'(done),          32'h0);
    check_eq("rst_err",         32'(err),           32'h0);
    check_eq("rst_ovf",         32'(ovf_flag),      32'h0);
    check_eq("rst_drop",        32'(ev_drop),       32'h0);
    @(posedge CLK_SLOW);
    #1;
    RSTn = 1'b1;
    @(posedge CLK_SLOW);
    #1;

    // Directed scenarios.
    run_seq(3'b001, 20, 0, -1, -1, -1, 1'b0);   // A5/3C, capture on the timeout boundary
    run_seq(3'b010,  8, 2, -1, -1, -1, 1'b0);   // ready held low 3 cycles
    run_seq(3'b001, -1, 0, -1, -1, -1, 1'b0);   // capture timeout
    run_seq(3'b001, 10, 0,  7, -1, -1, 1'b1);   // overflow in WAIT_CAP
    run_seq(3'b010,  6, 0, -1, -1, -1, 1'b1);   // flag cleared by next request
    run_seq(3'b010,  6, 0, -1, 12, -1, 1'b1);   // ev_req during SEND
    run_seq(3'b001,  6, 0, -1, -1, 11, 1'b1);   // abort on first SEND cycle
    run_seq(3'b011,  6, 0,  3, -1, 12, 1'b1);   // overflow kept across abort
    run_seq(3'b000, -1, 0,  1, -1, -1, 1'b1);   // mode off
    run_seq(3'b001,  5, 0, -1, -1,  0, 1'b1);   // abort with ev_req: nothing starts
    run_seq(3'b001,  2, 0, -1, -1,  3, 1'b1);   // capture during START, then abort
    run_seq(3'b001, -1, 0, -1, -1, -1, 1'b1);   // stale capture must not carry over
    run_seq(3'b110,  3, 0, -1,  2, -1, 1'b1);   // capture remembered from START

    // Randomized sequences.
    for (int n = 0; n < 60; n++) begin
      m_i = int'($urandom_range(6));
      r = int'($urandom_range(9));
      if (r < 2)      cap = int'($urandom_range(START_CYC, 1));
      else if (r < 8) cap = int'($urandom_range(START_CYC + TMO_CYC, START_CYC + 1));
      else            cap = -1;
      ovf = ($urandom_range(1) == 1) ? int'($urandom_range(30, 1)) : -1;
      drp = ($urandom_range(9) < 3) ? int'($urandom_range(30, 1)) : -1;
      abt = ($urandom_range(9) < 2) ? int'($urandom_range(30, 0)) : -1;
      run_seq(mode_tab[m_i], cap, int'($urandom_range(1)), ovf, drp, abt, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
